fdivsqrt_otfc4: RTL and testbench
=================================

Name: fdivsqrt_otfc4

Overview:
- Radix-4 on-the-fly converter (OTFC): the consumer side of the radix-4 quotient-digit selector.
- Accepts one signed-digit code per iteration, in the one-hot encoding the selector emits.
- Maintains the quotient Q and its decrement QM in non-redundant binary without carry-propagate adds.
- After a programmed number of digits, presents Q/QM to the post-processing stage with a valid/ready handshake.

Parameters:
- DIVb, 32, quotient width in bits; must be even and >= 4.
- ITER, DIVb/2, number of digits per operation (derived; not overridable).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- Start  input  1  begin new operation; clears Q/QM and the digit counter.
- Flush  input  1  abort; return to IDLE.
- DigitValid  input  1  UDigit valid this cycle.
- UDigit  input  4  one-hot digit: 1000=+2, 0100=+1, 0000=0, 0010=-1, 0001=-2.
- QReady  input  1  downstream accepts result.
- Q  output  DIVb  quotient.
- QM  output  DIVb  quotient minus one ulp.
- DigitCount  output  $clog2(ITER+1)  digits accepted in the current operation.
- Busy  output  1  high in RUN.
- QValid  output  1  high in DONE.
- DigitErr  output  1  sticky illegal-code flag; cleared by Start.

Behaviour:
- Reset (async, any state): state=IDLE, Q=0, QM=all ones, DigitCount=0, Busy=0, QValid=0, DigitErr=0.
- States: IDLE, RUN, DONE. Transitions on rising clk edge.
- IDLE:
  - Start -> RUN; Q=0, QM=all ones, DigitCount=0, DigitErr=0.
  - DigitValid is ignored.
- RUN:
  - Each cycle with DigitValid, shift in 2 bits. Q/QM are DIVb wide and the shift discards the top 2 bits (mod 2^DIVb wrap).
  - d=+2: Q={Q,10}, QM={Q,01}.
  - d=+1: Q={Q,01}, QM={Q,00}.
  - d=0: Q={Q,00}, QM={QM,11}.
  - d=-1: Q={QM,11}, QM={QM,10}.
  - d=-2: Q={QM,10}, QM={QM,01}.
  - DigitCount increments on each accepted digit.
  - A digit accepted while DigitCount==ITER-1 -> DONE on the same edge, QValid=1 next cycle.
  - DigitValid low: hold all state (stall).
- Illegal UDigit (more than one bit set) with DigitValid in RUN:
  - Processed as d=0.
  - DigitErr set and held until the next Start or reset.
- DONE:
  - Q, QM, DigitCount (=ITER) held stable while QValid=1.
  - QReady -> IDLE; Q/QM retain their values.
  - Start in DONE without QReady is ignored.
  - Start and QReady in the same cycle -> RUN, with the same clearing as from IDLE.
  - DigitValid is ignored.
- Start in RUN: restart (clear Q/QM/count/DigitErr, remain in RUN); the concurrent digit is discarded.
- Flush (any state) -> IDLE, Q=0, QM=all ones, DigitCount=0. Flush has priority over Start, DigitValid and QReady.
- Latency: ITER digit-accept cycles after Start, plus 0 stall cycles -> QValid asserted on the cycle after the final digit edge. Minimum operation = ITER+1 cycles from the Start edge to QValid.
- All outputs are registered; no combinational path from inputs to outputs.
- Invariant: Q - QM == 1 mod 2^DIVb at every clock edge in RUN and DONE.

Test Plan:
- DIVb=8; Start; digits +1,+1,+1,+1 back-to-back -> QValid on cycle 5 after Start, Q=0x55, QM=0x54, DigitCount=4.
- DIVb=8; digits +2,-1,0,-2 -> intermediate Q 0x02, 0x07, 0x1C, final Q=0x6E, QM=0x6D; QM sequence 0x01, 0x06, 0x1B, 0x6D.
- DIVb=8; digits -1,0,0,0 with DigitValid low for 2 cycles between digits 2 and 3 -> Q=0xC0, QM=0xBF; state frozen during the stall; QValid 7 cycles after Start.
- DIVb=8; hold QReady=0 in DONE for 5 cycles -> Q/QValid stable; Start alone ignored; QReady=1 with Start -> RUN with Q=0, QM=0xFF.
- Digit code 0110 -> processed as 0, DigitErr=1 persists through DONE, cleared by next Start.
- Assert reset mid-RUN after 2 digits -> immediately Q=0, QM=0xFF, Busy=0; Flush mid-RUN with Start also high -> IDLE.

Source files
------------

// File: rtl/fdivsqrt_otfc4_if.sv
`default_nettype none
// ============================================================================
//  Module      : fdivsqrt_otfc4_if
//  Description : Handshake/data bundle between the radix-4 digit selector,
//                the on-the-fly converter and the post-processing stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface fdivsqrt_otfc4_if #(
    parameter int DIVb = 32
);
    localparam int CW = $clog2(DIVb/2 + 1);

    logic            Start;
    logic            Flush;
    logic            DigitValid;
    logic [3:0]      UDigit;
    logic            QReady;
    logic [DIVb-1:0] Q;
    logic [DIVb-1:0] QM;
    logic [CW-1:0]   DigitCount;
    logic            Busy;
    logic            QValid;
    logic            DigitErr;

    // Digit selector / control side
    modport master (
        output Start, Flush, DigitValid, UDigit, QReady,
        input  Q, QM, DigitCount, Busy, QValid, DigitErr
    );

    // Converter side
    modport slave (
        input  Start, Flush, DigitValid, UDigit, QReady,
        output Q, QM, DigitCount, Busy, QValid, DigitErr
    );
endinterface
`default_nettype wire

// File: rtl/fdivsqrt_otfc4.sv
`default_nettype none
// ============================================================================
//  Module      : fdivsqrt_otfc4
//  Description : Radix-4 on-the-fly converter. Folds one-hot signed digits
//                into Q and QM (= Q - 1 ulp) without carry propagation and
//                hands the result over with a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module fdivsqrt_otfc4 #(
    parameter int DIVb = 32
) (
    input  logic               clk,
    input  logic               reset,
    fdivsqrt_otfc4_if.slave    bus
);
    localparam int ITER = DIVb / 2;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [1:0]      c_IDLE = 2'd0;
    localparam logic [1:0]      c_RUN  = 2'd1;
    localparam logic [1:0]      c_DONE = 2'd2;
    localparam logic [CW-1:0]   c_LAST = CW'(ITER - 1);
    localparam logic [DIVb-1:0] c_ONES = {DIVb{1'b1}};

    logic [1:0]      r_state;
    logic [DIVb-1:0] r_q;
    logic [DIVb-1:0] r_qm;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_qvalid;
    logic            r_err;

    logic [DIVb-1:0] w_q_nxt;
    logic [DIVb-1:0] w_qm_nxt;
    logic            w_illegal;

    // More than one hot bit is an illegal code; it is folded in as a zero digit.
    assign w_illegal = (bus.UDigit & (bus.UDigit - 4'd1)) != 4'd0;

    // Next Q/QM for the incoming digit: each selects Q or QM as the prefix.
    always_comb begin
        w_q_nxt  = {r_q[DIVb-3:0], 2'b00};
        w_qm_nxt = {r_qm[DIVb-3:0], 2'b11};
        case (bus.UDigit)
            4'b1000: begin
                w_q_nxt  = {r_q[DIVb-3:0], 2'b10};
                w_qm_nxt = {r_q[DIVb-3:0], 2'b01};
            end
            4'b0100: begin
                w_q_nxt  = {r_q[DIVb-3:0], 2'b01};
                w_qm_nxt = {r_q[DIVb-3:0], 2'b00};
            end
            4'b0010: begin
                w_q_nxt  = {r_qm[DIVb-3:0], 2'b11};
                w_qm_nxt = {r_qm[DIVb-3:0], 2'b10};
            end
            4'b0001: begin
                w_q_nxt  = {r_qm[DIVb-3:0], 2'b10};
                w_qm_nxt = {r_qm[DIVb-3:0], 2'b01};
            end
            default: begin
                w_q_nxt  = {r_q[DIVb-3:0], 2'b00};
                w_qm_nxt = {r_qm[DIVb-3:0], 2'b11};
            end
        endcase
    end

    // Control FSM plus Q/QM/count registers; Flush overrides every other request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_q      <= '0;
            r_qm     <= c_ONES;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_qvalid <= 1'b0;
            r_err    <= 1'b0;
        end else if (bus.Flush) begin
            r_state  <= c_IDLE;
            r_q      <= '0;
            r_qm     <= c_ONES;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_qvalid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.Start) begin
                        r_state  <= c_RUN;
                        r_q      <= '0;
                        r_qm     <= c_ONES;
                        r_cnt    <= '0;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_qvalid <= 1'b0;
                    end
                end
                c_RUN: begin
                    if (bus.Start) begin
                        // Restart: the digit presented alongside Start is dropped.
                        r_q   <= '0;
                        r_qm  <= c_ONES;
                        r_cnt <= '0;
                        r_err <= 1'b0;
                    end else if (bus.DigitValid) begin
                        r_q   <= w_q_nxt;
                        r_qm  <= w_qm_nxt;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end
                        if (r_cnt == c_LAST) begin
                            r_state  <= c_DONE;
                            r_busy   <= 1'b0;
                            r_qvalid <= 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    if (bus.QReady) begin
                        r_qvalid <= 1'b0;
                        if (bus.Start) begin
                            r_state <= c_RUN;
                            r_q     <= '0;
                            r_qm    <= c_ONES;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_busy   <= 1'b0;
                    r_qvalid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q          = r_q;
    assign bus.QM         = r_qm;
    assign bus.DigitCount = r_cnt;
    assign bus.Busy       = r_busy;
    assign bus.QValid     = r_qvalid;
    assign bus.DigitErr   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fdivsqrt_otfc4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fdivsqrt_otfc4
//  Description : Self-checking bench for the radix-4 on-the-fly converter,
//                DIVb=8. Reference keeps the quotient as a signed integer
//                value V = 4*V + d and reduces it mod 2^8.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fdivsqrt_otfc4;
    localparam int DIVb = 8;
    localparam int ITER = DIVb / 2;

    logic clk;
    logic reset;

    fdivsqrt_otfc4_if #(.DIVb(DIVb)) bus ();

    fdivsqrt_otfc4 #(.DIVb(DIVb)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    int m_v;
    int m_cnt;
    bit m_err;
    bit m_busy;
    bit m_qv;

    logic [3:0] c_legal [5] = '{4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b0001};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int dval(input logic [3:0] c);
        case (c)
            4'b1000: return 2;
            4'b0100: return 1;
            4'b0010: return -1;
            4'b0001: return -2;
            default: return 0;
        endcase
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".Q"},      32'(bus.Q),          32'(m_v & 255));
        chk({tag, ".QM"},     32'(bus.QM),         32'((m_v - 1) & 255));
        chk({tag, ".Count"},  32'(bus.DigitCount), 32'(m_cnt));
        chk({tag, ".Busy"},   32'(bus.Busy),       32'(m_busy));
        chk({tag, ".QValid"}, 32'(bus.QValid),     32'(m_qv));
        chk({tag, ".Err"},    32'(bus.DigitErr),   32'(m_err));
    endtask

    task automatic pulse_start();
        bus.Start      = 1'b1;
        bus.DigitValid = 1'($urandom_range(0, 1));
        bus.UDigit     = 4'($urandom);
        tick();
        bus.Start      = 1'b0;
        bus.DigitValid = 1'b0;
        m_v = 0; m_cnt = 0; m_err = 0; m_busy = 1; m_qv = 0;
    endtask

    task automatic feed(input logic [3:0] code, input int max_stall);
        int ns;
        ns = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        for (int s = 0; s < ns; s++) begin
            bus.DigitValid = 1'b0;
            bus.UDigit     = 4'($urandom);
            tick();
            check_all("stall");
        end
        bus.DigitValid = 1'b1;
        bus.UDigit     = code;
        tick();
        bus.DigitValid = 1'b0;
        m_v = m_v * 4 + dval(code);
        if ($countones(code) > 1) m_err = 1;
        m_cnt++;
        if (m_cnt == ITER) begin
            m_busy = 0;
            m_qv   = 1;
        end
        check_all("digit");
    endtask

    // Full operation: Start, ITER digits, DONE hold, release (optionally with Start).
    task automatic do_op(input logic [3:0] c[4], input int max_stall, input bit restart);
        int nh;
        pulse_start();
        check_all("start");
        for (int i = 0; i < ITER; i++) feed(c[i], max_stall);
        nh = $urandom_range(1, 5);
        for (int k = 0; k < nh; k++) begin
            bus.Start      = (k == 0);
            bus.DigitValid = 1'b1;
            bus.UDigit     = 4'($urandom);
            tick();
            check_all("done_hold");
        end
        bus.Start      = restart;
        bus.DigitValid = 1'b0;
        bus.QReady     = 1'b1;
        tick();
        bus.Start  = 1'b0;
        bus.QReady = 1'b0;
        m_qv = 0;
        if (restart) begin
            m_v = 0; m_cnt = 0; m_err = 0; m_busy = 1;
        end
        check_all("release");
        if (!restart) begin
            // Digits are ignored in IDLE
            bus.DigitValid = 1'b1;
            bus.UDigit     = 4'b1000;
            tick();
            bus.DigitValid = 1'b0;
            check_all("idle_ign");
        end
    endtask

    function automatic logic [3:0] pick(input bit allow_bad);
        logic [3:0] c;
        if (allow_bad && $urandom_range(0, 7) == 0) begin
            c = 4'b0011;
            do c = 4'($urandom); while ($countones(c) < 2);
            return c;
        end
        return c_legal[$urandom_range(0, 4)];
    endfunction

    logic [3:0] seq [4];

    initial begin
        bus.Start = 0; bus.Flush = 0; bus.DigitValid = 0; bus.UDigit = 0; bus.QReady = 0;
        reset = 1'b1;
        m_v = 0; m_cnt = 0; m_err = 0; m_busy = 0; m_qv = 0;
        #3;
        check_all("reset");
        #20 reset = 1'b0;
        tick();
        check_all("post_reset");

        // +1,+1,+1,+1 back-to-back -> 0x55 / 0x54
        seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100};
        do_op(seq, 0, 0);
        chk("dir1.Q", 32'(bus.Q), 32'h55);

        // +2,-1,0,-2 -> 0x6E / 0x6D
        seq = '{4'b1000, 4'b0010, 4'b0000, 4'b0001};
        do_op(seq, 0, 0);
        chk("dir2.QM", 32'(bus.QM), 32'h6D);

        // -1,0,0,0 with stalls -> 0xC0 / 0xBF; release with Start -> RUN cleared
        seq = '{4'b0010, 4'b0000, 4'b0000, 4'b0000};
        do_op(seq, 2, 1);

        // Illegal code 0110 processed as 0, sticky until next Start
        seq = '{4'b0100, 4'b0110, 4'b1000, 4'b0001};
        do_op(seq, 1, 0);
        pulse_start();
        check_all("err_clear");
        // Restart in RUN discards the concurrent digit
        feed(4'b1000, 0);
        bus.Start = 1'b1; bus.DigitValid = 1'b1; bus.UDigit = 4'b0100;
        tick();
        bus.Start = 1'b0; bus.DigitValid = 1'b0;
        m_v = 0; m_cnt = 0; m_err = 0;
        check_all("restart");

        // Random operations
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) seq[i] = pick(1'b1);
            do_op(seq, 3, 1'($urandom_range(0, 1)));
        end
        bus.QReady = 1'b0;

        // Async reset mid-RUN after 2 digits
        pulse_start();
        feed(4'b1000, 0);
        feed(4'b0100, 0);
        #2 reset = 1'b1;
        #1;
        m_v = 0; m_cnt = 0; m_err = 0; m_busy = 0; m_qv = 0;
        check_all("async_rst");
        #2 reset = 1'b0;
        tick();

        // Flush with Start mid-RUN -> IDLE
        pulse_start();
        feed(4'b0001, 0);
        feed(4'b0100, 0);
        bus.Flush = 1'b1; bus.Start = 1'b1; bus.DigitValid = 1'b1; bus.UDigit = 4'b1000;
        tick();
        bus.Flush = 1'b0; bus.Start = 1'b0; bus.DigitValid = 1'b0;
        chk("flush.Q",      32'(bus.Q),          32'h00);
        chk("flush.QM",     32'(bus.QM),         32'hFF);
        chk("flush.Count",  32'(bus.DigitCount), 32'd0);
        chk("flush.Busy",   32'(bus.Busy),       32'd0);
        chk("flush.QValid", 32'(bus.QValid),     32'd0);
        // Still idle one cycle later despite a digit
        bus.DigitValid = 1'b1; bus.UDigit = 4'b0100;
        tick();
        bus.DigitValid = 1'b0;
        chk("flush_idle.Q", 32'(bus.Q), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
